interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
Parametrised interrupt front-end for the B322 CPU. It replaces the four fixed per-line stabilizers and the fixed interrupt selection with a single block that handles NUM_INT lines. Each line gets a synchronizer, rising-edge detection, a pending latch, software masking and fixed priority. The block hands the PC one vector at a time, only at instruction boundaries (writeBack strobe), and blocks nesting until reti retires.

Parameters:
NUM_INT, 4, number of interrupt lines (legal range 1..32)
SYNC_STAGES, 2, synchronizer flops per line (minimum 2)
ADDR_W, 27, width of the vector address, matching PC/jump_addr
VEC_BASE, 1, address of vector 0; vector n = VEC_BASE + n
ID_W, derived, max(1, clog2(NUM_INT)); not user-overridable

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
int_in  in  NUM_INT  raw asynchronous interrupt lines; bit 0 has highest priority
writeBack  in  1  instruction-boundary strobe from Timer; one cycle per instruction
reti  in  1  return-from-interrupt decoded; qualified by writeBack
mask_we  in  1  write-enable for the mask register
mask_d  in  NUM_INT  new mask value; 1 = line masked
mask_q  out  NUM_INT  current mask register
pending_q  out  NUM_INT  current pending latches
irq_take  out  1  one-cycle pulse: PC must jump to irq_vec
irq_id  out  ID_W  index of the taken interrupt
irq_vec  out  ADDR_W  vector address of the taken interrupt
in_service  out  1  high from take until reti retires

Behaviour:
- Reset (synchronous): all sync flops, edge history, pending_q, mask_q, irq_take, irq_id, irq_vec and in_service go to 0. All lines are unmasked after reset.
- Synchronizer: int_in[n] passes through a SYNC_STAGES flop chain. An edge is detected when the last stage is 1 and was 0 on the previous cycle (one extra history flop). Levels are ignored; only rising edges set pending.
- Latency: a clean 0->1 on int_in sets pending_q[n] on clock edge SYNC_STAGES+1, counting the first capturing edge as 1.
- The pending bit stays set until that line is taken. Masking does not clear it. A masked pending line is taken once it is unmasked.
- eligible = pending_q & ~mask_q. Selection is the lowest set index of eligible, which is purely combinational.
- FSM states:
  - IDLE: on an edge with writeBack=1 and eligible!=0, the controller registers irq_take=1, irq_id=sel and irq_vec=VEC_BASE+sel (ADDR_W arithmetic, wraps modulo 2^ADDR_W). It also clears pending_q[sel] and goes to SERVICE.
  - SERVICE: in_service=1 and no takes. On an edge with writeBack=1 and reti=1, it goes to IDLE. A take can happen at the earliest on the next writeBack after the return.
  - reti in IDLE is ignored.
- irq_take is high exactly one cycle, the cycle after the sampling edge. irq_id and irq_vec hold their values until the next take.
- Simultaneous set and clear of the same bit (new edge on the edge where that line is taken): set wins, so the bit stays pending for a later service.
- mask_we: mask_q <= mask_d on the edge. A take on the same edge uses the old mask.
- Edges arriving during SERVICE are latched in pending and are not lost. Repeated edges on an already-pending line collapse into one.
- Reset asserted during SERVICE returns the block to IDLE and discards all pending bits.
- No combinational path from int_in to any output.

Test Plan:
- NUM_INT=4, SYNC_STAGES=2: pulse int_in[2] for 1 cycle -> pending_q=4'b0100 after 3 edges. At the next writeBack, irq_take pulses for 1 cycle with irq_id=2, irq_vec=3, pending_q=0 and in_service=1.
- int_in[3] and int_in[1] rise together, then writeBack -> line 1 taken first (vec 2). writeBack+reti, then the next writeBack -> line 3 taken (vec 4).
- mask_q=4'b0001 via mask_we, pulse int_in[0] -> pending_q[0]=1 and no take over 10 writeBacks. Write mask 0 -> take id 0 on the next writeBack.
- During SERVICE, pulse int_in[1] twice -> pending_q[1]=1 with no take. reti alone without writeBack -> stays in SERVICE. writeBack+reti -> IDLE, then exactly one take of id 1.
- Edge on int_in[0] timed to reach pending on the same edge line 0 is taken -> irq_take=1 and pending_q[0] remains 1. A second take of id 0 follows after reti.
- NUM_INT=1, ID_W=1: reset asserted mid-SERVICE with pending set -> next cycle all outputs 0, in_service=0 and no take until a fresh edge arrives.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt front-end and the CPU core: raw lines, the
// instruction-boundary handshake, the mask register port and the take vector.
interface interrupt_controller_if #(
   parameter int NUM_INT = 4,
   parameter int ADDR_W  = 27
);
   localparam int ID_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

   logic [NUM_INT-1:0] int_in;
   logic               writeBack;
   logic               reti;
   logic               mask_we;
   logic [NUM_INT-1:0] mask_d;
   logic [NUM_INT-1:0] mask_q;
   logic [NUM_INT-1:0] pending_q;
   logic               irq_take;
   logic [ID_W-1:0]    irq_id;
   logic [ADDR_W-1:0]  irq_vec;
   logic               in_service;

   // Controller side
   modport slave (
      input  int_in, writeBack, reti, mask_we, mask_d,
      output mask_q, pending_q, irq_take, irq_id, irq_vec, in_service
   );

   // CPU / stimulus side
   modport master (
      output int_in, writeBack, reti, mask_we, mask_d,
      input  mask_q, pending_q, irq_take, irq_id, irq_vec, in_service
   );
endinterface

// File: rtl/interrupt_controller.sv
// Parametrised interrupt front-end: per-line synchronizer, rising-edge
// detection, pending latches, software mask and fixed priority (bit 0 wins).
// One vector is handed out per instruction boundary and nesting is blocked
// until reti retires. Every output comes straight from a flop.
module interrupt_controller #(
   parameter int          NUM_INT     = 4,
   parameter int          SYNC_STAGES = 2,
   parameter int          ADDR_W      = 27,
   parameter int unsigned VEC_BASE    = 1
) (
   input logic                    clk,
   input logic                    reset,
   interrupt_controller_if.slave  bus
);
   localparam int ID_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
   logic [NUM_INT-1:0] sync_d [SYNC_STAGES];
   logic [NUM_INT-1:0] hist_q, hist_d;
   logic [NUM_INT-1:0] pending_q, pending_d;
   logic [NUM_INT-1:0] mask_q, mask_d;
   logic               irq_take_q, irq_take_d;
   logic [ID_W-1:0]    irq_id_q, irq_id_d;
   logic [ADDR_W-1:0]  irq_vec_q, irq_vec_d;
   logic               in_service_q, in_service_d;

   logic [NUM_INT-1:0] rise_s;
   logic [NUM_INT-1:0] eligible_s;
   logic [NUM_INT-1:0] clear_s;
   logic [ID_W-1:0]    sel_s;
   logic               take_s;

   // Synchronizer chain shift, edge history and rising-edge detect
   always_comb begin
      sync_d[0] = bus.int_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
      hist_d = sync_q[SYNC_STAGES-1];
      rise_s = sync_q[SYNC_STAGES-1] & ~hist_q;
   end

   // Eligible lines and lowest-index priority select
   always_comb begin
      eligible_s = pending_q & ~mask_q;
      sel_s      = {ID_W{1'b0}};
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         sel_s = eligible_s[i] ? ID_W'(i) : sel_s;
      end
   end

   // Take / service state machine: next state and take decision
   always_comb begin
      state_d = state_q;
      take_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.writeBack && (|eligible_s)) begin
               take_s  = 1'b1;
               state_d = SERVICE;
            end else begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (bus.writeBack && bus.reti) begin
               state_d = IDLE;
            end else begin
               state_d = SERVICE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pending set/clear (a new edge beats the clear), mask write, take registers
   always_comb begin
      for (int i = 0; i < NUM_INT; i++) begin
         clear_s[i] = take_s && (sel_s == ID_W'(i));
      end
      pending_d    = (pending_q & ~clear_s) | rise_s;
      mask_d       = bus.mask_we ? bus.mask_d : mask_q;
      irq_take_d   = take_s;
      irq_id_d     = take_s ? sel_s : irq_id_q;
      irq_vec_d    = take_s ? (ADDR_W'(VEC_BASE) + ADDR_W'(sel_s)) : irq_vec_q;
      in_service_d = (state_d == SERVICE);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= {NUM_INT{1'b0}};
         end
         hist_q       <= {NUM_INT{1'b0}};
         pending_q    <= {NUM_INT{1'b0}};
         mask_q       <= {NUM_INT{1'b0}};
         irq_take_q   <= 1'b0;
         irq_id_q     <= {ID_W{1'b0}};
         irq_vec_q    <= {ADDR_W{1'b0}};
         in_service_q <= 1'b0;
         state_q      <= IDLE;
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_d[s];
         end
         hist_q       <= hist_d;
         pending_q    <= pending_d;
         mask_q       <= mask_d;
         irq_take_q   <= irq_take_d;
         irq_id_q     <= irq_id_d;
         irq_vec_q    <= irq_vec_d;
         in_service_q <= in_service_d;
         state_q      <= state_d;
      end
   end

   assign bus.mask_q     = mask_q;
   assign bus.pending_q  = pending_q;
   assign bus.irq_take   = irq_take_q;
   assign bus.irq_id     = irq_id_q;
   assign bus.irq_vec    = irq_vec_q;
   assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: a 4-line instance checked every cycle
// against a reference model through scoreboard queues, plus a 1-line
// instance exercised with directed checks around reset during service.
module tb_interrupt_controller;
   logic clk;
   logic rst4, rst1;

   interrupt_controller_if #(.NUM_INT(4), .ADDR_W(27)) if4 ();
   interrupt_controller_if #(.NUM_INT(1), .ADDR_W(27)) if1 ();

   interrupt_controller #(.NUM_INT(4), .SYNC_STAGES(2), .ADDR_W(27), .VEC_BASE(1)) dut4 (
      .clk(clk), .reset(rst4), .bus(if4)
   );
   interrupt_controller #(.NUM_INT(1), .SYNC_STAGES(2), .ADDR_W(27), .VEC_BASE(1)) dut1 (
      .clk(clk), .reset(rst1), .bus(if1)
   );

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      logic        take;
      logic [3:0]  pend;
      logic [3:0]  mask;
      logic        svc;
      logic [1:0]  id;
      logic [26:0] vec;
   } snap_t;

   typedef struct {
      logic [1:0]  id;
      logic [26:0] vec;
   } take_t;

   snap_t statq[$];
   take_t takeq[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model of the 4-line instance ----------------
   logic [3:0]  m_pend, m_mask;
   logic        m_svc, m_take;
   logic [1:0]  m_id;
   logic [26:0] m_vec;
   logic [3:0]  samp[$];

   initial begin
      logic [3:0] rise, elig, clr;
      int sel;
      snap_t sn;
      take_t tk;
      m_pend = 4'd0; m_mask = 4'd0; m_svc = 1'b0; m_take = 1'b0;
      m_id = 2'd0; m_vec = 27'd0;
      samp = {4'd0, 4'd0, 4'd0};
      forever begin
         @(posedge clk);
         if (rst4) begin
            m_pend = 4'd0; m_mask = 4'd0; m_svc = 1'b0; m_take = 1'b0;
            m_id = 2'd0; m_vec = 27'd0;
            samp = {4'd0, 4'd0, 4'd0};
         end else begin
            // a line becomes pending two edges after its input is first seen high
            rise   = samp[1] & ~samp[2];
            elig   = m_pend & ~m_mask;
            m_take = 1'b0;
            clr    = 4'd0;
            if (!m_svc && if4.writeBack && elig != 4'd0) begin
               sel = 0;
               for (int b = 0; b < 4; b++) begin
                  if (elig[b]) begin
                     sel = b;
                     break;
                  end
               end
               m_take = 1'b1;
               m_id   = 2'(sel);
               m_vec  = 27'(1 + sel);
               m_svc  = 1'b1;
               clr[sel] = 1'b1;
               tk.id  = m_id;
               tk.vec = m_vec;
               takeq.push_back(tk);
            end else if (m_svc && if4.writeBack && if4.reti) begin
               m_svc = 1'b0;
            end
            m_pend = (m_pend & ~clr) | rise;
            if (if4.mask_we) m_mask = if4.mask_d;
            samp.push_front(if4.int_in);
            void'(samp.pop_back());
         end
         sn.take = m_take; sn.pend = m_pend; sn.mask = m_mask;
         sn.svc = m_svc; sn.id = m_id; sn.vec = m_vec;
         statq.push_back(sn);
      end
   end

   // ---------------- monitor: pops expectations and compares ----------------
   initial begin
      snap_t sn;
      take_t tk;
      forever begin
         @(negedge clk);
         if (statq.size() > 0) begin
            sn = statq.pop_front();
            chk("irq_take",   32'(if4.irq_take),   32'(sn.take));
            chk("pending_q",  32'(if4.pending_q),  32'(sn.pend));
            chk("mask_q",     32'(if4.mask_q),     32'(sn.mask));
            chk("in_service", 32'(if4.in_service), 32'(sn.svc));
            chk("irq_id_hold",  32'(if4.irq_id),   32'(sn.id));
            chk("irq_vec_hold", 32'(if4.irq_vec),  32'(sn.vec));
         end
         if (if4.irq_take === 1'b1) begin
            if (takeq.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL take_unexpected: actual irq_id=%0d with no take expected at %0t", if4.irq_id, $time);
            end else begin
               tk = takeq.pop_front();
               chk("take_id",  32'(if4.irq_id),  32'(tk.id));
               chk("take_vec", 32'(if4.irq_vec), 32'(tk.vec));
            end
         end
      end
   end

   // ---------------- stimulus helpers (4-line instance) ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      repeat (n) step();
   endtask

   task automatic pulse(input logic [3:0] m);
      if4.int_in = if4.int_in | m;
      step();
      if4.int_in = if4.int_in & ~m;
   endtask

   task automatic wbk(input logic r);
      if4.writeBack = 1'b1;
      if4.reti      = r;
      step();
      if4.writeBack = 1'b0;
      if4.reti      = 1'b0;
   endtask

   task automatic mask_wr(input logic [3:0] m);
      if4.mask_we = 1'b1;
      if4.mask_d  = m;
      step();
      if4.mask_we = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst4 = 1'b1; rst1 = 1'b1;
      if4.int_in = 4'd0; if4.writeBack = 1'b0; if4.reti = 1'b0;
      if4.mask_we = 1'b0; if4.mask_d = 4'd0;
      if1.int_in = 1'b0; if1.writeBack = 1'b0; if1.reti = 1'b0;
      if1.mask_we = 1'b0; if1.mask_d = 1'b0;
      step();
      rst4 = 1'b0; rst1 = 1'b0;
      step();

      // single pulse on line 2, then return
      pulse(4'b0100); wait_n(3); wbk(1'b0); wait_n(2); wbk(1'b1);
      // lines 3 and 1 together: 1 first, 3 after return
      pulse(4'b1010); wait_n(3); wbk(1'b0); wait_n(1); wbk(1'b1);
      wbk(1'b0); wait_n(1); wbk(1'b1);
      // masked pending line waits until unmasked
      mask_wr(4'b0001); pulse(4'b0001); wait_n(3);
      repeat (10) begin wbk(1'b0); wait_n(1); end
      mask_wr(4'b0000); wbk(1'b0); wait_n(1); wbk(1'b1);
      // edges during service latch and collapse; bare reti is ignored
      pulse(4'b0100); wait_n(3); wbk(1'b0);
      pulse(4'b0010); wait_n(2); pulse(4'b0010); wait_n(3);
      if4.reti = 1'b1; step(); if4.reti = 1'b0;
      wait_n(2); wbk(1'b1); wbk(1'b0); wait_n(1); wbk(1'b0); wbk(1'b1);
      // new edge on line 0 lands on the edge that takes line 0
      pulse(4'b0001); wait_n(5);
      if4.int_in = 4'b0001; step(); step();
      if4.writeBack = 1'b1; step(); if4.writeBack = 1'b0;
      chk("setwins_take",    32'(if4.irq_take),     32'd1);
      chk("setwins_pending", 32'(if4.pending_q[0]), 32'd1);
      chk("setwins_id",      32'(if4.irq_id),       32'd0);
      if4.int_in = 4'b0000; wait_n(2); wbk(1'b1); wbk(1'b0);
      chk("setwins_second_take", 32'(if4.irq_take), 32'd1);
      wait_n(1); wbk(1'b1);

      // ---------------- 1-line instance: reset during service ----------------
      if1.int_in = 1'b1; wait_n(3);
      chk("n1_pending_set", 32'(if1.pending_q), 32'd1);
      if1.writeBack = 1'b1; step(); if1.writeBack = 1'b0;
      chk("n1_take",    32'(if1.irq_take),   32'd1);
      chk("n1_vec",     32'(if1.irq_vec),    32'd1);
      chk("n1_service", 32'(if1.in_service), 32'd1);
      chk("n1_cleared", 32'(if1.pending_q),  32'd0);
      if1.int_in = 1'b0; wait_n(2); if1.int_in = 1'b1; wait_n(3); if1.int_in = 1'b0;
      chk("n1_pend_in_svc", 32'(if1.pending_q), 32'd1);
      wait_n(2);
      rst1 = 1'b1; step(); rst1 = 1'b0;
      chk("n1_rst_pending", 32'(if1.pending_q),  32'd0);
      chk("n1_rst_service", 32'(if1.in_service), 32'd0);
      chk("n1_rst_take",    32'(if1.irq_take),   32'd0);
      chk("n1_rst_id",      32'(if1.irq_id),     32'd0);
      chk("n1_rst_vec",     32'(if1.irq_vec),    32'd0);
      chk("n1_rst_mask",    32'(if1.mask_q),     32'd0);
      if1.writeBack = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("n1_no_take", 32'(if1.irq_take), 32'd0);
      end
      if1.writeBack = 1'b0;
      if1.int_in = 1'b1; wait_n(3);
      if1.writeBack = 1'b1; step(); if1.writeBack = 1'b0;
      chk("n1_fresh_take", 32'(if1.irq_take), 32'd1);

      // ---------------- randomized traffic on the 4-line instance ----------------
      for (int c = 0; c < 3000; c++) begin
         rst4 = ($urandom_range(0, 299) == 0);
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 7) == 0) if4.int_in[b] = ~if4.int_in[b];
         end
         if4.writeBack = ($urandom_range(0, 2) == 0);
         if4.reti      = 1'($urandom_range(0, 1));
         if4.mask_we   = ($urandom_range(0, 19) == 0);
         if4.mask_d    = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         step();
      end
      rst4 = 1'b0;
      if4.int_in = 4'd0; if4.writeBack = 1'b0; if4.reti = 1'b0; if4.mask_we = 1'b0;
      wait_n(4);
      chk("takeq_drained", 32'(takeq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
